// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter for the pipelined core.
// Multiplexes the instruction-fetch and data ports onto one RAM port.
// Data requests have priority. A running access is never preempted.
// A fetch or data request withdrawn mid-access is drained to completion
// on the RAM side, and no hit is issued for it.
// A per-access timeout forces completion with 32'hBAD1BAD1 and sets a
// sticky err flag.
// Optional feature: define IFETCH_BUF_EN to add a one-entry fetch buffer.
module mem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    // instruction fetch port
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        ihit,
    output logic [31:0] iload,
    // data port
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dhit,
    output logic [31:0] dload,
    // RAM port
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_rdy,
    // sticky timeout flag
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DACC  = 2'd1,
        IACC  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Wide enough to hold TIMEOUT-1 for any TIMEOUT >= 1.
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [CW-1:0] cnt;

    logic          d_req;
    logic          at_limit;
    logic          acc_done;
    logic [31:0]   load_word;
    logic          dacc_hit;
    logic          iacc_hit;
    logic          buf_hit;
    logic [31:0]   buf_word;

    assign d_req     = dREN | dWEN;
    // A timed-out access completes exactly like a ram_rdy cycle.
    assign at_limit  = (cnt == CW'(TIMEOUT - 1));
    assign acc_done  = ram_rdy | at_limit;
    assign load_word = ram_rdy ? ramload : 32'hBAD1BAD1;

    // Hits are combinational in the completion cycle. A request that was
    // dropped in that same cycle gets no hit.
    assign dacc_hit = (state == DACC) && d_req && acc_done;
    assign iacc_hit = (state == IACC) && iREN && acc_done;

    assign dhit  = dacc_hit;
    assign dload = dacc_hit ? load_word : 32'h0;
    assign ihit  = iacc_hit | buf_hit;
    // buf_hit is never true in IACC, so the two fetch sources cannot collide.
    assign iload = buf_hit  ? buf_word  :
                   iacc_hit ? load_word : 32'h0;

`ifdef IFETCH_BUF_EN
    logic        buf_valid;
    logic [29:0] buf_addr;
    logic [31:0] buf_data;

    assign buf_hit  = iREN && buf_valid && (iaddr[31:2] == buf_addr) && (state != IACC);
    assign buf_word = buf_data;

    // Fetch buffer: refill on every RAM fetch completion, drop on a write to the same word.
    always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: the buffer tag and data are reset along with valid. This keeps
        // the compare free of X, although valid alone would be enough to gate it.
        if (!nRST) begin
            buf_valid <= 1'b0;
            buf_addr  <= 30'h0;
            buf_data  <= 32'h0;
        end else if (iacc_hit) begin
            buf_valid <= 1'b1;
            buf_addr  <= ramaddr[31:2];
            buf_data  <= load_word;
        end else if (ramWEN && acc_done && (state != IDLE) &&
                     (ramaddr[31:2] == buf_addr)) begin
            // Covers both a normal store and a drained one. A drained
            // store may still have reached the RAM.
            buf_valid <= 1'b0;
        end
    end
`else
    assign buf_hit  = 1'b0;
    assign buf_word = 32'h0;
`endif

    // Access FSM. The RAM strobes, address and store data are the entry registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= 32'h0;
            ramstore <= 32'h0;
            cnt      <= '0;
            err      <= 1'b0;
        end else begin
            // NOTE: all state uses non-blocking assignment, so every branch
            // below sees the pre-edge values of state, cnt and the strobes.
            if ((state != IDLE) && at_limit && !ram_rdy)
                err <= 1'b1;

            case (state)
                IDLE: begin
                    if (d_req) begin
                        state    <= DACC;
                        ramREN   <= dREN;
                        ramWEN   <= dWEN;
                        ramaddr  <= daddr;
                        ramstore <= dstore;
                        cnt      <= '0;
                    end else if (iREN && !buf_hit) begin
                        state    <= IACC;
                        ramREN   <= 1'b1;
                        ramWEN   <= 1'b0;
                        ramaddr  <= iaddr;
                        cnt      <= '0;
                    end
                end

                DACC, IACC: begin
                    if (acc_done) begin
                        state  <= IDLE;
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                    end else if ((state == DACC) ? !d_req : !iREN) begin
                        // The requester flushed. The RAM still owns the
                        // access, so keep the latched strobes until it finishes.
                        state <= DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                DRAIN: begin
                    if (acc_done) begin
                        state  <= IDLE;
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: begin
                    state  <= IDLE;
                    ramREN <= 1'b0;
                    ramWEN <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the pipelined core. It is the responder side of the fetch/data request interface whose `ihit`/`dhit` outputs drive the hazard unit's stall and flush decisions. It multiplexes the instruction-fetch port and the data (load/store) port onto one RAM port, giving data requests priority, and returns per-port hit strobes and read data. An optional single-entry fetch buffer lets repeated fetches of the same PC hit without a RAM access.

## Interface
Parameters:
- TIMEOUT, 64: maximum cycles an access waits for `ram_rdy` before it is forced to complete with an error.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  instruction fetch request; level, held until `ihit`.
- iaddr  in  32  fetch address; word aligned.
- ihit  out  1  fetch complete this cycle.
- iload  out  32  fetch data; valid when `ihit`=1.
- dREN  in  1  data read request; level, held until `dhit`.
- dWEN  in  1  data write request; level, held until `dhit`. Never asserted together with `dREN`.
- daddr  in  32  data address; word aligned.
- dstore  in  32  write data.
- dhit  out  1  data access complete this cycle.
- dload  out  32  read data; valid when `dhit`=1 and `dREN`=1.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data; valid with `ram_rdy`.
- ram_rdy  in  1  RAM access done this cycle.
- err  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, DACC, IACC, DRAIN.
- IDLE:
  - If `dREN|dWEN`, go to DACC.
  - Otherwise, if `iREN` and there is no buffer hit, go to IACC.
  - RAM strobes are 0 in IDLE.
- DACC: drives `ramaddr=daddr`, `ramREN=dREN`, `ramWEN=dWEN`, `ramstore=dstore`. On `ram_rdy`: `dhit`=1 combinationally, `dload=ramload`, then go to IDLE.
- IACC: drives `ramaddr=iaddr`, `ramREN=1`, `ramWEN=0`. On `ram_rdy`: `ihit`=1, `iload=ramload`, then go to IDLE.
- Request withdrawn mid-access (`iREN` or the data request drops before `ram_rdy`, e.g. on a pipeline flush):
  - Go to DRAIN, which holds the RAM strobes and address latched at state entry until `ram_rdy`.
  - No hit is issued; then go to IDLE.
- Entry registers: a 32-bit address, a 32-bit data word and the strobes are latched on entry to DACC/IACC. DRAIN uses these latched values.
- Timeout counter:
  - Cleared on entry to DACC, IACC or DRAIN; increments each cycle `ram_rdy`=0.
  - On reaching TIMEOUT-1 the access completes as if `ram_rdy`=1, with load data forced to 32'hBAD1BAD1, and `err` is set.
  - `err` stays set until reset.
- `ihit` and `dhit` are never 1 in the same cycle from RAM accesses. A buffer hit (see Configuration) may coincide with `dhit`.
- Reset values: state IDLE, all strobes 0, `ihit`=`dhit`=0, `iload`=`dload`=0, `ramaddr`=`ramstore`=0, `err`=0, counter 0.

## Timing
- Minimum access: 1 cycle in DACC/IACC when `ram_rdy` is already 1 there. The hit is combinational in that cycle.
- One IDLE cycle always separates consecutive RAM accesses. The requester updates its request in the cycle after the hit.
- Data priority: if `iREN` and `dREN` are both asserted in IDLE, the data access is served first. Fetch starts two cycles after `dhit` at the earliest.
- A data request arriving during IACC waits for the fetch to complete; there is no preemption.
- Reset asserted mid-access: strobes drop asynchronously and the in-flight access is abandoned.

## Configuration
- IFETCH_BUF_EN defined:
  - Adds a one-entry buffer (valid, addr[31:2], data), loaded on every IACC completion, including timeouts.
  - Buffer hit condition: `iREN`, valid, and `iaddr[31:2]` equal to the stored address, in any state except IACC. On a hit, `ihit`=1 in the same cycle and `iload`=buffer data, with no RAM access.
  - A DACC write completion with `daddr[31:2]` equal to the stored address clears valid.
  - Valid resets to 0.
- IFETCH_BUF_EN undefined: no buffer, and every fetch goes through IACC.

## Test plan
- Single fetch: `iREN`=1, `iaddr`=0x40, `ram_rdy` after 2 cycles with `ramload`=0x8C010004 -> `ihit` pulses once with `iload`=0x8C010004, `ramREN`=1 for exactly 2 cycles.
- Priority: `iREN` and `dREN` both asserted in IDLE, `daddr`=0x100 -> `ramaddr`=0x100 first, `dhit` precedes `ihit`, with one IDLE cycle between the accesses.
- Store: `dWEN`=1, `daddr`=0x200, `dstore`=0xDEADBEEF -> `ramWEN`=1 with `ramstore`=0xDEADBEEF, `dhit` on `ram_rdy`, `ramREN`=0 throughout.
- Flush: `iREN` drops one cycle into IACC -> DRAIN keeps the strobes until `ram_rdy`, no `ihit`, then IDLE.
- Timeout with TIMEOUT=4 and `ram_rdy` held 0 -> hit on the 4th cycle with load 0xBAD1BAD1, and `err`=1 until `nRST`.
- With IFETCH_BUF_EN: fetch 0x40 twice -> the second `ihit` comes in the request cycle with no RAM strobe. After a store to 0x40, the next fetch of 0x40 goes to RAM.
